// File: rtl/mem_arbiter.sv
// Two-master (IFU = 0, LSU = 1) arbiter for the single shared memory port.
// Fixed LSU priority by default; define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, IFU_REQ, IFU_RESP, LSU_REQ, LSU_RESP} state_t;

  state_t state_reg, state_next;
  logic   pick_lsu;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

`ifdef MEM_ARB_RR_EN
  // last_grant: 0 = IFU, 1 = LSU; follows the most recently completed transaction.
  logic last_grant;

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b0;
    else if (state_reg == IFU_RESP && mem_resp_valid && ifu_resp_ready)
      last_grant <= 1'b0;
    else if (state_reg == LSU_RESP && mem_resp_valid && lsu_resp_ready)
      last_grant <= 1'b1;
  end

  assign pick_lsu = lsu_req_valid && !(ifu_req_valid && last_grant);
`else
  assign pick_lsu = lsu_req_valid;
`endif

  assign busy = (state_reg != IDLE);

  always_comb begin
    state_next     = state_reg;
    grant          = 2'b00;
    mem_req_valid  = 1'b0;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    mem_resp_ready = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_lsu)           state_next = LSU_REQ;
        else if (ifu_req_valid) state_next = IFU_REQ;
      end
      IFU_REQ: begin
        grant         = 2'b01;
        mem_req_valid = ifu_req_valid;
        mem_addr      = ifu_addr;
        ifu_req_ready = mem_req_ready;
        // A withdrawn request abandons the grant without forwarding anything.
        if (!ifu_req_valid)     state_next = IDLE;
        else if (mem_req_ready) state_next = IFU_RESP;
      end
      IFU_RESP: begin
        grant          = 2'b01;
        ifu_resp_valid = mem_resp_valid;
        ifu_rdata      = mem_rdata;
        mem_resp_ready = ifu_resp_ready;
        if (mem_resp_valid && ifu_resp_ready) state_next = IDLE;
      end
      LSU_REQ: begin
        grant         = 2'b10;
        mem_req_valid = lsu_req_valid;
        mem_addr      = lsu_addr;
        mem_wen       = lsu_wen;
        mem_wdata     = lsu_wdata;
        mem_wmask     = lsu_wmask;
        lsu_req_ready = mem_req_ready;
        if (!lsu_req_valid)     state_next = IDLE;
        else if (mem_req_ready) state_next = LSU_RESP;
      end
      LSU_RESP: begin
        grant          = 2'b10;
        lsu_resp_valid = mem_resp_valid;
        lsu_rdata      = mem_rdata;
        mem_resp_ready = lsu_resp_ready;
        if (mem_resp_valid && lsu_resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter: one row per clock cycle, outputs checked before the edge.
// A hand-written sequence covers bounded-wait request latency and response routing.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic [1:0]  grant;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy)
  );

  typedef struct {
    logic        rst;
    logic        iv;  logic [31:0] ia;  logic irr;
    logic        lv;  logic [31:0] la;  logic lw;  logic [31:0] wd;  logic [3:0] wm;  logic lrr;
    logic        mrq; logic        mrv; logic [31:0] rd;
    logic [9:0]  ctl;
    logic [31:0] ma;  logic [31:0] mwd; logic [3:0] mwm;
    logic [31:0] ird; logic [31:0] lrd;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // Control word layout: {grant, busy, mem_req_valid, mem_wen, ifu_req_ready,
  // lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_resp_ready}
  function automatic logic [9:0] ctl(input logic [1:0] g, input logic mrv, input logic wen,
                                     input logic irq, input logic lrq, input logic irv,
                                     input logic lrv, input logic mrr);
    return {g, (g != 2'b00), mrv, wen, irq, lrq, irv, lrv, mrr};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    rst = r.rst;
    ifu_req_valid = r.iv;  ifu_addr = r.ia;  ifu_resp_ready = r.irr;
    lsu_req_valid = r.lv;  lsu_addr = r.la;  lsu_wen = r.lw;
    lsu_wdata = r.wd;      lsu_wmask = r.wm; lsu_resp_ready = r.lrr;
    mem_req_ready = r.mrq; mem_resp_valid = r.mrv; mem_rdata = r.rd;
  endtask

  logic [9:0] act_ctl;
  assign act_ctl = {grant, busy, mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready,
                    ifu_resp_valid, lsu_resp_valid, mem_resp_ready};

  localparam logic [1:0] G0 = 2'b00, GI = 2'b01, GL = 2'b10;

  initial begin
    logic [1:0]  rr_g;
    logic [31:0] rr_a;
    int          lat;
`ifdef MEM_ARB_RR_EN
    rr_g = GI; rr_a = 32'h200;
`else
    rr_g = GL; rr_a = 32'h300;
`endif
    // rst iv ia irr | lv la lw wd wm lrr | mrq mrv rd | ctl | ma mwd mwm | ird lrd
    // reset state, stray response in IDLE
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 32'h1234, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    // single IFU fetch (stray response during request phase ignored)
    vecs.push_back('{0, 1, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hBAD, ctl(GI,1,0,1,0,0,0,0), 32'h80000000, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h413, ctl(GI,0,0,0,0,1,0,1), 0, 0, 0, 32'h413, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    // LSU store with 4-cycle memory stall; IFU request waits
    vecs.push_back('{0, 0, 0, 0, 1, 32'h80001000, 1, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{0, 1, 32'h80000004, 0, 1, 32'h80001000, 1, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, ctl(GL,1,1,0,0,0,0,0), 32'h80001000, 32'hDEADBEEF, 4'hF, 0, 0});
    vecs.push_back('{0, 1, 32'h80000004, 0, 1, 32'h80001000, 1, 32'hDEADBEEF, 4'hF, 0, 1, 0, 0, ctl(GL,1,1,0,1,0,0,0), 32'h80001000, 32'hDEADBEEF, 4'hF, 0, 0});
    vecs.push_back('{0, 1, 32'h80000004, 1, 0, 0, 0, 0, 0, 1, 0, 1, 32'h5A5A, ctl(GL,0,0,0,0,0,1,1), 0, 0, 0, 0, 32'h5A5A});
    vecs.push_back('{0, 1, 32'h80000004, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 32'h80000004, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ctl(GI,1,0,1,0,0,0,0), 32'h80000004, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111, ctl(GI,0,0,0,0,1,0,1), 0, 0, 0, 32'h11111111, 0});
    // simultaneous requests: LSU first, with response backpressure while IFU waits
    vecs.push_back('{0, 1, 32'h80000008, 0, 1, 32'h80002000, 0, 0, 0, 0, 0, 0, 0, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 32'h80000008, 0, 1, 32'h80002000, 0, 0, 0, 0, 1, 0, 0, ctl(GL,1,0,0,1,0,0,0), 32'h80002000, 0, 0, 0, 0});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{0, 1, 32'h80000008, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFEF00D, ctl(GL,0,0,0,0,0,1,0), 0, 0, 0, 0, 32'hCAFEF00D});
    vecs.push_back('{0, 1, 32'h80000008, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hCAFEF00D, ctl(GL,0,0,0,0,0,1,1), 0, 0, 0, 0, 32'hCAFEF00D});
    vecs.push_back('{0, 1, 32'h80000008, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 32'h80000008, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ctl(GI,1,0,1,0,0,0,0), 32'h80000008, 0, 0, 0, 0});
    // reset mid-transaction in IFU_RESP, then a stray response
    vecs.push_back('{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl(GI,0,0,0,0,0,0,1), 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEADDEAD, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    // request withdrawal before memory accepts
    vecs.push_back('{0, 1, 32'h80000010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 32'h80000010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl(GI,1,0,0,0,0,0,0), 32'h80000010, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 32'h80000010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl(GI,0,0,0,0,0,0,0), 32'h80000010, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    // LSU completes, then simultaneous requests: fixed priority vs round-robin
    vecs.push_back('{0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 1, 0, 0, ctl(GL,1,0,0,1,0,0,0), 32'h100, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h7, ctl(GL,0,0,0,0,0,1,1), 0, 0, 0, 0, 32'h7});
    vecs.push_back('{0, 1, 32'h200, 0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 32'h200, 0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0, ctl(rr_g,1,0,0,0,0,0,0), rr_a, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl(rr_g,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl(G0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0});

    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_ctl", i), 64'(act_ctl), 64'(vecs[i].ctl));
      check($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].ma));
      check($sformatf("v%0d_mem_wdata_wmask", i), {28'h0, mem_wdata, mem_wmask}, {28'h0, vecs[i].mwd, vecs[i].mwm});
      check($sformatf("v%0d_ifu_rdata", i), 64'(ifu_rdata), 64'(vecs[i].ird));
      check($sformatf("v%0d_lsu_rdata", i), 64'(lsu_rdata), 64'(vecs[i].lrd));
      $display("[TB] vector %0d applied: grant=%b busy=%b", i, grant, busy);
    end

    // Hand sequence: LSU load; request accepted one bubble cycle after being raised.
    @(negedge clk);
    rst = 0; ifu_req_valid = 0; lsu_req_valid = 1; lsu_addr = 32'h400; lsu_wen = 0;
    lsu_wdata = 0; lsu_wmask = 0; mem_req_ready = 1; mem_resp_valid = 0; lsu_resp_ready = 0;
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (lsu_req_ready) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check("lsu_req_latency", 64'(lat), 64'd1);
    check("lsu_load_mem_addr", 64'(mem_addr), 64'h400);
    @(negedge clk);
    lsu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hABCD; lsu_resp_ready = 1;
    #1;
    check("lsu_load_resp", {lsu_resp_valid, ifu_resp_valid, mem_resp_ready, lsu_rdata, ifu_rdata},
          {1'b1, 1'b0, 1'b1, 32'hABCD, 32'h0});
    @(negedge clk);
    mem_resp_valid = 0; lsu_resp_ready = 0;
    #1;
    check("lsu_load_done_idle", {busy, grant}, 3'b000);
    $display("[TB] hand sequence lsu load done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter for the single shared memory port.
- Masters: instruction fetch (IFU, master 0) and load/store (LSU, master 1).
- Each transaction is one request handshake followed by one response handshake, using the same valid/ready rules as the pipeline stages.
- Sits between if/ex and the memory bridge; one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MASK_W, DATA_W/8, byte write-mask width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU request valid
- ifu_req_ready  out  1  IFU request accepted
- ifu_addr  in  ADDR_W  fetch address (read only)
- ifu_resp_valid  out  1  fetch data valid
- ifu_resp_ready  in  1  IFU can take response
- ifu_rdata  out  DATA_W  fetch data
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  LSU request accepted
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  MASK_W  store byte mask
- lsu_resp_valid  out  1  load data / store ack valid
- lsu_resp_ready  in  1  LSU can take response
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  forwarded address
- mem_wen  out  1  forwarded write enable
- mem_wdata  out  DATA_W  forwarded store data
- mem_wmask  out  MASK_W  forwarded store mask
- mem_resp_valid  in  1  memory response valid
- mem_resp_ready  out  1  arbiter accepts response
- mem_rdata  in  DATA_W  memory response data
- grant  out  2  one-hot owner: bit0 = IFU, bit1 = LSU; 0 when IDLE
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- States: IDLE, IFU_REQ, IFU_RESP, LSU_REQ, LSU_RESP. Only the state register is sequential; all outputs are decoded combinationally from state and inputs.
- Reset: state = IDLE. In IDLE every output valid/ready is 0, grant = 0, busy = 0, and mem_addr/mem_wdata/mem_wmask/mem_wen = 0.
- IDLE arbitration: LSU has fixed priority.
  - lsu_req_valid -> LSU_REQ.
  - else ifu_req_valid -> IFU_REQ.
  - else stay in IDLE.
- Arbitration costs one bubble cycle: a request raised in cycle N is driven on mem_req_valid in cycle N+1 at the earliest.
- X_REQ (request phase, X = granted master):
  - mem_req_valid = x_req_valid; mem fields muxed from X. IFU drives mem_wen = 0, wdata = 0, wmask = 0.
  - x_req_ready = mem_req_ready. The other master sees req_ready = 0.
  - On handshake (mem_req_valid && mem_req_ready) -> X_RESP.
  - If x_req_valid drops before handshake (protocol violation) -> IDLE, nothing forwarded.
- X_RESP (response phase):
  - x_resp_valid = mem_resp_valid; x_rdata = mem_rdata; mem_resp_ready = x_resp_ready.
  - The other master sees resp_valid = 0 and rdata = 0.
  - On handshake -> IDLE.
  - No back-to-back grant: minimum transaction length is 3 cycles (IDLE, REQ, RESP, each 1 cycle when zero-wait).
- Stray traffic:
  - mem_resp_valid in IDLE or X_REQ is ignored (mem_resp_ready = 0).
  - A master's req_valid while the other master owns the port simply waits; its req_ready = 0.
- Simultaneous ifu_req_valid and lsu_req_valid in IDLE: LSU is granted; IFU is granted in the next IDLE.
- Reset asserted mid-transaction: the next state is IDLE regardless; the in-flight transaction is dropped and memory-side cleanup is not the arbiter's job.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_grant register (reset 0 = IFU) updates on each response handshake.
  - On simultaneous requests in IDLE, the master not in last_grant wins.
  - A single requester always wins.
- Undefined: fixed LSU priority as above; last_grant does not exist.

Test Plan:
- Single IFU fetch:
  - Stimulus: ifu_req_valid = 1, addr 0x80000000; mem_req_ready = 1; mem_resp_valid the next cycle with rdata 0x00000413; ifu_resp_ready = 1.
  - Required: grant = 01; mem_addr = 0x80000000, mem_wen = 0; ifu_rdata = 0x00000413; back to IDLE after 3 cycles.
- LSU store with memory stall:
  - Stimulus: addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF; mem_req_ready held 0 for 4 cycles.
  - Required: mem_req_valid stays 1 with stable fields; lsu_req_ready rises in the same cycle as mem_req_ready; response routed to LSU only.
- Simultaneous requests:
  - Stimulus: IFU and LSU valid in the same IDLE cycle.
  - Required: LSU served first (grant = 10), then IFU (grant = 01). With MEM_ARB_RR_EN defined and last_grant = LSU, IFU is served first.
- Response backpressure:
  - Stimulus: mem_resp_valid = 1, lsu_resp_ready = 0 for 3 cycles.
  - Required: mem_resp_ready = 0, state stays LSU_RESP, lsu_rdata stable; IFU request pending meanwhile gets no ready.
- Reset mid-transaction:
  - Stimulus: rst = 1 in IFU_RESP.
  - Required: next cycle state IDLE, grant = 0, busy = 0, all valid/ready outputs 0; a stray mem_resp_valid afterwards is not forwarded.
- Request withdrawal:
  - Stimulus: IFU drops req_valid in IFU_REQ before mem_req_ready.
  - Required: return to IDLE; mem_req_valid deasserted the same cycle.
